// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Covers FSM states, access sizes, region nibbles and the region-select struct.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  localparam logic [3:0] REGION_ROM   = 4'h0;
  localparam logic [3:0] REGION_RAM   = 4'h1;
  localparam logic [3:0] REGION_PERIF = 4'h2;

  localparam int WAIT_W   = 8;
  localparam int STREAK_W = 8;

  typedef struct packed {
    logic unused;
    logic perif;
    logic ram;
    logic rom;
  } region_sel_t;

  function automatic logic [63:0] size_mask(input size_e size);
    case (size)
      SZ_BYTE:  size_mask = 64'h0000_0000_0000_00FF;
      SZ_HALF:  size_mask = 64'h0000_0000_0000_FFFF;
      SZ_WORD:  size_mask = 64'h0000_0000_FFFF_FFFF;
      default:  size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [2:0] addr_lo);
    case (size)
      SZ_HALF:  misaligned = addr_lo[0];
      SZ_WORD:  misaligned = |addr_lo[1:0];
      SZ_DWORD: misaligned = |addr_lo;
      default:  misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decode: one-hot region, access error and wait-state count
// for a candidate address/size/direction.
module mem_region_decode
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROM_WAIT   = 0,
  parameter int RAM_WAIT   = 1,
  parameter int PERIF_WAIT = 2
) (
  input  logic [31:0]       addr_i,
  input  size_e             size_i,
  input  logic              we_i,
  output region_sel_t       region_o,
  output logic              err_o,
  output logic [WAIT_W-1:0] wait_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    region_o = '0;
    wait_o   = '0;
    case (addr_i[31:28])
      REGION_ROM: begin
        region_o.rom = 1'b1;
        wait_o       = WAIT_W'(ROM_WAIT);
      end
      REGION_RAM: begin
        region_o.ram = 1'b1;
        wait_o       = WAIT_W'(RAM_WAIT);
      end
      REGION_PERIF: begin
        region_o.perif = 1'b1;
        wait_o         = WAIT_W'(PERIF_WAIT);
      end
      default: region_o.unused = 1'b1;
    endcase
    err_o = region_o.unused | (region_o.rom & we_i) | misaligned(size_i, addr_i[2:0]);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single wait-stated memory bus with
// data priority bounded by a streak limit while a fetch is pending.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROM_WAIT    = 0,
  parameter int RAM_WAIT    = 1,
  parameter int PERIF_WAIT  = 2,
  parameter int MAX_DSTREAK = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [63:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [63:0] mem_wdata,
  output logic        mem_write_en,
  output logic [1:0]  mem_size,
  input  logic [63:0] mem_rdata,
  output logic        ROM_select,
  output logic        RAM_select,
  output logic        PERIF_select,
  output logic        UNUSED_select,
  output logic        busy
);

  state_e              state_q,  state_d;
  logic [31:0]         addr_q,   addr_d;
  size_e               size_q,   size_d;
  logic                we_q,     we_d;
  logic [63:0]         wdata_q,  wdata_d;
  logic                fetch_q,  fetch_d;
  logic                err_q,    err_d;
  region_sel_t         region_q, region_d;
  logic [WAIT_W-1:0]   wait_q,   wait_d;
  logic [63:0]         rdata_q,  rdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic              grant_fetch;
  logic [31:0]       sel_addr;
  size_e             sel_size;
  logic              sel_we;
  region_sel_t       dec_region;
  logic              dec_err;
  logic [WAIT_W-1:0] dec_wait;

  assign grant_fetch = if_req & (~d_req | (streak_q == STREAK_W'(MAX_DSTREAK)));
  assign sel_addr    = grant_fetch ? if_addr : d_addr;
  assign sel_size    = grant_fetch ? SZ_WORD : size_e'(d_size);
  assign sel_we      = grant_fetch ? 1'b0    : d_we;

  mem_region_decode #(
    .ROM_WAIT   (ROM_WAIT),
    .RAM_WAIT   (RAM_WAIT),
    .PERIF_WAIT (PERIF_WAIT)
  ) u_decode (
    .addr_i   (sel_addr),
    .size_i   (sel_size),
    .we_i     (sel_we),
    .region_o (dec_region),
    .err_o    (dec_err),
    .wait_o   (dec_wait)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    fetch_d  = fetch_q;
    err_d    = err_q;
    region_d = region_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req | d_req) begin
          addr_d   = sel_addr;
          size_d   = sel_size;
          we_d     = sel_we;
          wdata_d  = grant_fetch ? 64'd0 : d_wdata;
          fetch_d  = grant_fetch;
          err_d    = dec_err;
          region_d = dec_region;
          wait_d   = dec_wait;
          rdata_d  = '0;
          if (grant_fetch)  streak_d = '0;
          else if (if_req)  streak_d = streak_q + STREAK_W'(1);
          state_d  = dec_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          rdata_d = mem_rdata & size_mask(size_q);
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so every output is 0 the cycle after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      fetch_q  <= 1'b0;
      err_q    <= 1'b0;
      region_q <= '0;
      wait_q   <= '0;
      rdata_q  <= '0;
      streak_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      fetch_q  <= fetch_d;
      err_q    <= err_d;
      region_q <= region_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    mem_address   = '0;
    mem_wdata     = '0;
    mem_write_en  = 1'b0;
    mem_size      = '0;
    ROM_select    = 1'b0;
    RAM_select    = 1'b0;
    PERIF_select  = 1'b0;
    UNUSED_select = 1'b0;
    if_ack        = 1'b0;
    if_err        = 1'b0;
    if_rdata      = '0;
    d_ack         = 1'b0;
    d_err         = 1'b0;
    d_rdata       = '0;
    if (state_q == ST_ACCESS) begin
      mem_address   = addr_q;
      mem_wdata     = wdata_q;
      mem_write_en  = we_q;
      mem_size      = size_q;
      ROM_select    = region_q.rom;
      RAM_select    = region_q.ram;
      PERIF_select  = region_q.perif;
      UNUSED_select = region_q.unused;
    end else if (state_q == ST_RESP) begin
      if (fetch_q) begin
        if_ack   = 1'b1;
        if_err   = err_q;
        if_rdata = rdata_q[31:0];
      end else begin
        d_ack   = 1'b1;
        d_err   = err_q;
        d_rdata = rdata_q;
      end
    end
  end

endmodule
